// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-port synchronous RAM between the
//                instruction-fetch and data ports. Data has priority, and
//                instruction starvation is bounded.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  I_req,
    input  logic [31:0]           I_addr,
    output logic                  I_gnt,
    output logic                  I_rd_valid,
    output logic [31:0]           I_rd_data,
    input  logic                  D_req,
    input  logic                  D_wr_en,
    input  logic [31:0]           D_addr,
    input  logic [3:0]            D_wr_byte_en,
    input  logic [31:0]           D_wr_data,
    output logic                  D_gnt,
    output logic                  D_rd_valid,
    output logic [31:0]           D_rd_data,
    output logic                  Bus_err,
    output logic                  MEM_en,
    output logic                  MEM_wr_en,
    output logic [ADDR_WIDTH-1:0] MEM_addr,
    output logic [3:0]            MEM_wr_byte_en,
    output logic [31:0]           MEM_wr_data,
    input  logic [31:0]           MEM_rd_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_ERR  = 2'd3
    } owner_t;

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    owner_t      r_owner;
    logic        r_i_rd_valid;
    logic        r_d_rd_valid;
    logic [31:0] r_i_rd_data;
    logic [31:0] r_d_rd_data;

    logic        w_starve_hit;
    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_any_gnt;
    logic        w_oor;
    logic [31:0] w_addr;
    logic [31:0] w_i_rd_word;
    logic [31:0] w_d_rd_word;
    logic [1:0]  w_unused_addr_lsbs;

    always_comb begin
        w_starve_hit = (r_starve_cnt == C_STARVE_LIMIT);
        w_d_gnt      = !Reset && D_req && !(I_req && w_starve_hit);
        w_i_gnt      = !Reset && I_req && !w_d_gnt;
        w_any_gnt    = w_i_gnt || w_d_gnt;
        w_addr       = w_d_gnt ? D_addr : I_addr;
    end

    // Byte offset is irrelevant to a word RAM; lanes are chosen by byte enables.
    assign w_unused_addr_lsbs = w_addr[1:0];

    generate
        if (ADDR_WIDTH < 30) begin : g_range_chk
            assign w_oor = |w_addr[31:ADDR_WIDTH+2];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign I_gnt          = w_i_gnt;
    assign D_gnt          = w_d_gnt;
    assign MEM_en         = w_any_gnt && !w_oor;
    assign MEM_wr_en      = w_d_gnt && D_wr_en && !w_oor;
    assign MEM_wr_byte_en = MEM_wr_en ? D_wr_byte_en : 4'b0000;
    assign MEM_wr_data    = D_wr_data;
    assign MEM_addr       = w_addr[ADDR_WIDTH+1:2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve_cnt <= 4'd0;
            r_owner      <= OWN_NONE;
            r_i_rd_valid <= 1'b0;
            r_d_rd_valid <= 1'b0;
            r_i_rd_data  <= 32'd0;
            r_d_rd_data  <= 32'd0;
        end else begin
            if (I_req && !w_i_gnt) begin
                r_starve_cnt <= w_starve_hit ? r_starve_cnt : r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= 4'd0;
            end

            r_i_rd_valid <= w_i_gnt;
            r_d_rd_valid <= w_d_gnt && !D_wr_en;

            if (w_any_gnt && w_oor) begin
                r_owner <= OWN_ERR;
            end else if (w_i_gnt) begin
                r_owner <= OWN_I;
            end else if (w_d_gnt && !D_wr_en) begin
                r_owner <= OWN_D;
            end else begin
                r_owner <= OWN_NONE;
            end

            // Capture the returned word so each port holds it until its next read.
            if (r_i_rd_valid) begin
                r_i_rd_data <= w_i_rd_word;
            end
            if (r_d_rd_valid) begin
                r_d_rd_data <= w_d_rd_word;
            end
        end
    end

    // An errored read returns zero instead of whatever the RAM last drove.
    assign w_i_rd_word = (r_owner == OWN_I) ? MEM_rd_data : 32'd0;
    assign w_d_rd_word = (r_owner == OWN_D) ? MEM_rd_data : 32'd0;

    // Reset masks the return strobes so an in-flight read never surfaces.
    assign I_rd_valid = r_i_rd_valid && !Reset;
    assign D_rd_valid = r_d_rd_valid && !Reset;
    assign Bus_err    = (r_owner == OWN_ERR) && !Reset;
    assign I_rd_data  = I_rd_valid ? w_i_rd_word : r_i_rd_data;
    assign D_rd_data  = D_rd_valid ? w_d_rd_word : r_d_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Self-checking bench for unified_mem_arbiter with RAM model
//                and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int AW    = 14;
    localparam int LIM   = 3;
    localparam int DEPTH = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          I_req = 1'b0;
    logic [31:0]   I_addr = 32'd0;
    logic          I_gnt, I_rd_valid;
    logic [31:0]   I_rd_data;
    logic          D_req = 1'b0, D_wr_en = 1'b0;
    logic [31:0]   D_addr = 32'd0, D_wr_data = 32'd0;
    logic [3:0]    D_wr_byte_en = 4'd0;
    logic          D_gnt, D_rd_valid;
    logic [31:0]   D_rd_data;
    logic          Bus_err, MEM_en, MEM_wr_en;
    logic [AW-1:0] MEM_addr;
    logic [3:0]    MEM_wr_byte_en;
    logic [31:0]   MEM_wr_data, MEM_rd_data;

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .Clk(Clk), .Reset(Reset),
        .I_req(I_req), .I_addr(I_addr), .I_gnt(I_gnt),
        .I_rd_valid(I_rd_valid), .I_rd_data(I_rd_data),
        .D_req(D_req), .D_wr_en(D_wr_en), .D_addr(D_addr),
        .D_wr_byte_en(D_wr_byte_en), .D_wr_data(D_wr_data), .D_gnt(D_gnt),
        .D_rd_valid(D_rd_valid), .D_rd_data(D_rd_data), .Bus_err(Bus_err),
        .MEM_en(MEM_en), .MEM_wr_en(MEM_wr_en), .MEM_addr(MEM_addr),
        .MEM_wr_byte_en(MEM_wr_byte_en), .MEM_wr_data(MEM_wr_data),
        .MEM_rd_data(MEM_rd_data)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM: read-before-write, 1-cycle read latency.
    logic [31:0] ram [DEPTH];
    always @(posedge Clk) begin
        if (MEM_en) begin
            MEM_rd_data <= ram[MEM_addr];
            if (MEM_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (MEM_wr_byte_en[b]) ram[MEM_addr][8*b +: 8] = MEM_wr_data[8*b +: 8];
                end
            end
        end
    end

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_streak = 0;
    logic [31:0] m_mem [DEPTH];
    logic        e_i_v = 1'b0, e_d_v = 1'b0, e_err = 1'b0;
    logic [31:0] e_i_dat = 32'd0, e_d_dat = 32'd0, e_i_hold = 32'd0, e_d_hold = 32'd0;
    logic        m_gi = 1'b0, m_gd = 1'b0;

    // Called at a negedge with inputs applied; checks the cycle, advances the model.
    task automatic do_cycle();
        logic          gi, gd, oor, we;
        logic [31:0]   a;
        logic [AW-1:0] idx;
        #1;
        if (Reset) begin
            gi = 1'b0; gd = 1'b0;
        end else if (I_req && D_req) begin
            gi = (m_streak == LIM);
            gd = !gi;
        end else begin
            gi = I_req; gd = D_req;
        end
        a   = gd ? D_addr : I_addr;
        oor = (a >> (AW + 2)) != 0;
        we  = gd && D_wr_en && !oor;
        idx = a[AW+1:2];

        chk("i_gnt", 32'(I_gnt), 32'(gi));
        chk("d_gnt", 32'(D_gnt), 32'(gd));
        chk("mem_en", 32'(MEM_en), 32'((gi || gd) && !oor));
        chk("mem_wr_en", 32'(MEM_wr_en), 32'(we));
        chk("mem_be", 32'(MEM_wr_byte_en), 32'(we ? D_wr_byte_en : 4'h0));
        if ((gi || gd) && !oor) chk("mem_addr", 32'(MEM_addr), 32'(idx));
        if (we) chk("mem_wr_data", MEM_wr_data, D_wr_data);

        if (Reset) begin
            chk("i_rd_valid_rst", 32'(I_rd_valid), 32'd0);
            chk("d_rd_valid_rst", 32'(D_rd_valid), 32'd0);
            chk("bus_err_rst", 32'(Bus_err), 32'd0);
        end else begin
            chk("i_rd_valid", 32'(I_rd_valid), 32'(e_i_v));
            chk("d_rd_valid", 32'(D_rd_valid), 32'(e_d_v));
            chk("bus_err", 32'(Bus_err), 32'(e_err));
            chk("i_rd_data", I_rd_data, e_i_v ? e_i_dat : e_i_hold);
            chk("d_rd_data", D_rd_data, e_d_v ? e_d_dat : e_d_hold);
        end

        if (Reset) begin
            e_i_v = 0; e_d_v = 0; e_err = 0;
            e_i_hold = 0; e_d_hold = 0;
            m_streak = 0;
        end else begin
            if (e_i_v) e_i_hold = e_i_dat;
            if (e_d_v) e_d_hold = e_d_dat;
            e_i_v   = gi;
            e_d_v   = gd && !D_wr_en;
            e_err   = (gi || gd) && oor;
            e_i_dat = oor ? 32'd0 : m_mem[idx];
            e_d_dat = e_i_dat;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (D_wr_byte_en[b]) m_mem[idx][8*b +: 8] = D_wr_data[8*b +: 8];
            end
            if (I_req && !gi) m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
            else              m_streak = 0;
        end
        m_gi = gi;
        m_gd = gd;
        @(negedge Clk);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom | 32'h0001_0000;
        if ($urandom_range(0, 15) == 0) return 32'((DEPTH - 1) << 2) | 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
    endfunction

    typedef struct {
        logic i_req;
        logic d_req;
        logic exp_i;
        logic exp_d;
    } vec_t;
    vec_t tbl [18];

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0}
        };
        for (int k = 0; k < DEPTH; k++) begin
            ram[k]   = init_word(k);
            m_mem[k] = ram[k];
        end
        ram[0]   = 32'h00000013;
        m_mem[0] = 32'h00000013;
        @(negedge Clk);

        // Reset for two cycles with a pending fetch of address 0
        Reset = 1'b1; I_req = 1'b1; I_addr = 32'h0;
        do_cycle();
        do_cycle();
        chk("rst_i_rd_data", I_rd_data, 32'd0);
        chk("rst_d_rd_data", D_rd_data, 32'd0);
        chk("rst_bus_err", 32'(Bus_err), 32'd0);
        Reset = 1'b0;
        #1 chk("t1_i_gnt", 32'(I_gnt), 32'd1);
        do_cycle();
        I_req = 1'b0;
        chk("t1_i_rd_valid", 32'(I_rd_valid), 32'd1);
        chk("t1_i_rd_data", I_rd_data, 32'h00000013);
        do_cycle();

        // Arbitration table
        I_addr = 32'h100; D_addr = 32'h200; D_wr_en = 1'b0;
        for (int k = 0; k < 18; k++) begin
            I_req = tbl[k].i_req;
            D_req = tbl[k].d_req;
            #1;
            chk($sformatf("tbl%0d_i_gnt", k), 32'(I_gnt), 32'(tbl[k].exp_i));
            chk($sformatf("tbl%0d_d_gnt", k), 32'(D_gnt), 32'(tbl[k].exp_d));
            do_cycle();
        end

        // Byte-lane write then read back
        I_req = 1'b0; D_req = 1'b1; D_wr_en = 1'b1; D_addr = 32'h2004;
        D_wr_byte_en = 4'b0010; D_wr_data = 32'h0000AB00;
        #1 chk("t3_wr_be", 32'(MEM_wr_byte_en), 32'h2);
        do_cycle();
        D_wr_en = 1'b0;
        do_cycle();
        D_req = 1'b0;
        chk("t3_rd_data", D_rd_data, (init_word(32'h801) & 32'hFFFF00FF) | 32'h0000AB00);
        do_cycle();

        // Out-of-range read
        D_req = 1'b1; D_wr_en = 1'b0; D_addr = 32'h0010_0000;
        #1 chk("t4_mem_en", 32'(MEM_en), 32'd0);
        do_cycle();
        D_req = 1'b0;
        chk("t4_bus_err", 32'(Bus_err), 32'd1);
        chk("t4_d_rd_valid", 32'(D_rd_valid), 32'd1);
        chk("t4_d_rd_data", D_rd_data, 32'd0);
        do_cycle();
        chk("t4_bus_err_pulse", 32'(Bus_err), 32'd0);

        // Starved fetch granted, then reset drops it and clears starvation
        I_req = 1'b1; I_addr = 32'h40; D_req = 1'b1; D_addr = 32'h80;
        for (int k = 0; k < 3; k++) do_cycle();
        #1 chk("t5_i_gnt", 32'(I_gnt), 32'd1);
        do_cycle();
        Reset = 1'b1;
        #1 chk("t5_rd_valid_in_rst", 32'(I_rd_valid), 32'd0);
        do_cycle();
        Reset = 1'b0;
        chk("t5_rd_valid_after_rst", 32'(I_rd_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t5_pattern%0d", k), 32'(I_gnt), 32'(k == 3));
            do_cycle();
        end
        I_req = 1'b0; D_req = 1'b0;
        do_cycle();

        // Alternating I/D reads
        for (int k = 0; k < 12; k++) begin
            I_req  = (k % 2) == 0;
            D_req  = (k % 2) == 1;
            I_addr = 32'($urandom_range(0, 255) << 2);
            D_addr = 32'($urandom_range(0, 255) << 2);
            do_cycle();
        end
        I_req = 1'b0; D_req = 1'b0;
        do_cycle();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (!I_req && $urandom_range(0, 9) < 6) begin
                I_req = 1'b1; I_addr = rand_addr();
            end
            if (!D_req && $urandom_range(0, 9) < 6) begin
                D_req = 1'b1; D_wr_en = $urandom_range(0, 1) == 1; D_addr = rand_addr();
                D_wr_byte_en = 4'($urandom); D_wr_data = $urandom;
            end
            Reset = ($urandom_range(0, 99) == 0);
            do_cycle();
            if (m_gi) I_req = 1'b0;
            if (m_gd) D_req = 1'b0;
        end
        Reset = 1'b0; I_req = 1'b0; D_req = 1'b0;
        do_cycle();
        do_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
